// File: rtl/logicnets_argmax_decoder.sv
// Argmax output stage for a LogicNets classifier. It captures the final-layer
// vector and scans the class scores one per cycle. It returns the winning
// class over a valid/ready handshake and counts the results handed off.
module logicnets_argmax_decoder #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned SCORE_BITS  = 3,
    parameter int unsigned IDX_BITS    = 2,
    parameter int unsigned CNT_BITS    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CLASSES*SCORE_BITS-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_BITS-1:0]               out_class,
    output logic [SCORE_BITS-1:0]             out_score,
    output logic [CNT_BITS-1:0]               out_count
);

    localparam int unsigned DATA_W = NUM_CLASSES * SCORE_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_W-1:0]     data_q;
    logic [IDX_BITS-1:0]   scan_idx;
    logic [IDX_BITS-1:0]   best_idx;
    logic [SCORE_BITS-1:0] best_score;

    logic [SCORE_BITS-1:0] cur_score;
    logic                  cur_gt;
    logic                  scan_last;
    logic [IDX_BITS-1:0]   best_idx_nxt;
    logic [SCORE_BITS-1:0] best_score_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Select the score under inspection and fold it into the running best
    always_comb begin
        cur_score = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            if (scan_idx == IDX_BITS'(k)) begin
                cur_score = data_q[k*SCORE_BITS +: SCORE_BITS];
            end
        end
        // Strictly greater only, so a tie keeps the lower index
        cur_gt         = cur_score > best_score;
        best_idx_nxt   = cur_gt ? scan_idx  : best_idx;
        best_score_nxt = cur_gt ? cur_score : best_score;
        scan_last      = scan_idx == IDX_BITS'(NUM_CLASSES - 1);
    end

    // Capture, scan and result registers; reset discards any work in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_score <= '0;
            out_class  <= '0;
            out_score  <= '0;
            out_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        best_idx   <= '0;
                        best_score <= in_data[SCORE_BITS-1:0];
                        scan_idx   <= IDX_BITS'(1);
                    end
                end
                SCAN: begin
                    best_idx   <= best_idx_nxt;
                    best_score <= best_score_nxt;
                    if (scan_last) begin
                        out_class <= best_idx_nxt;
                        out_score <= best_score_nxt;
                    end else begin
                        scan_idx <= scan_idx + IDX_BITS'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_count <= out_count + CNT_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logicnets_argmax_decoder.sv
// Scoreboard bench for logicnets_argmax_decoder, built with a 4-bit counter
// so that the wrap can be reached.
module tb_logicnets_argmax_decoder;

    localparam int unsigned NC = 4;
    localparam int unsigned SB = 3;
    localparam int unsigned IB = 2;
    localparam int unsigned CB = 4;
    localparam int unsigned DW = NC * SB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [IB-1:0] out_class;
    logic [SB-1:0] out_score;
    logic [CB-1:0] out_count;

    logicnets_argmax_decoder #(
        .NUM_CLASSES(NC),
        .SCORE_BITS (SB),
        .IDX_BITS   (IB),
        .CNT_BITS   (CB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_score(out_score),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc      = 0;
    int            acc_cyc  = 0;
    logic          prev_ov  = 1'b0;
    logic          saw_valid = 1'b0;
    logic          rand_bp  = 1'b0;
    logic [CB-1:0] exp_cnt  = '0;
    logic [IB+SB-1:0] pending_exp = '0;
    logic [IB+SB-1:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference argmax: {class, score}, first maximum wins
    function automatic logic [IB+SB-1:0] ref_max(input logic [DW-1:0] d);
        logic [SB-1:0] best;
        logic [SB-1:0] s;
        logic [IB-1:0] bi;
        best = d[SB-1:0];
        bi   = '0;
        for (int k = 1; k < int'(NC); k++) begin
            s = d[k*SB +: SB];
            if (s > best) begin
                best = s;
                bi   = IB'(k);
            end
        end
        return {bi, best};
    endfunction

    function automatic logic [DW-1:0] pack(input int s0, input int s1, input int s2, input int s3);
        return {SB'(s3), SB'(s2), SB'(s1), SB'(s0)};
    endfunction

    // Observe what the coming rising edge will sample (inputs only change at negedge)
    task automatic monitor();
        logic [IB+SB-1:0] e;
        if (rst === 1'b1) begin
            sb_q.delete();
            exp_cnt = '0;
            prev_ov = 1'b0;
        end else begin
            if (out_valid === 1'b1) begin
                saw_valid = 1'b1;
                // Accept edge plus NUM_CLASSES-1 scan edges precede the first valid sample
                if (!prev_ov) check("latency", 32'(cyc - acc_cyc), 32'(NC));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("out_class", 32'(out_class), 32'(e[IB+SB-1:SB]));
                    check("out_score", 32'(out_score), 32'(e[SB-1:0]));
                end
                check("out_count", 32'(out_count), 32'(exp_cnt));
                exp_cnt = exp_cnt + CB'(1);
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb_q.push_back(pending_exp);
                acc_cyc = cyc;
            end
            prev_ov = (out_valid === 1'b1);
        end
    endtask

    // One clock: monitor, rising edge, then back to the falling edge
    task automatic step();
        monitor();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [IB+SB-1:0] exp);
        logic acc;
        acc         = 1'b0;
        in_valid    = 1'b1;
        in_data     = d;
        pending_exp = exp;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = (in_ready === 1'b1);
            step();
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
        check("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb_q.size() != 0 || out_valid === 1'b1); i++) step();
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = pack(7, 1, 2, 3);
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);

        // Reset held with in_valid high: nothing captured
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_out_score", 32'(out_score), 32'd0);
        check("rst_no_capture", 32'(sb_q.size()), 32'd0);
        saw_valid = 1'b0;
        repeat (3) step();
        check("rst_idle_quiet", 32'(saw_valid), 32'd0);

        // Basic argmax
        send(pack(3, 5, 2, 1), {2'd1, 3'd5});
        drain();
        check("basic_count", 32'(out_count), 32'd1);

        // Ties and extremes
        send(pack(6, 6, 6, 6), {2'd0, 3'd6});
        send(pack(0, 0, 0, 7), {2'd3, 3'd7});
        send(pack(7, 0, 0, 7), {2'd0, 3'd7});
        send(pack(0, 0, 0, 0), {2'd0, 3'd0});
        drain();
        check("ties_count", 32'(out_count), 32'd5);

        // Backpressure: result held, new data ignored
        out_ready = 1'b0;
        send(pack(1, 4, 4, 2), {2'd1, 3'd4});
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            in_data = DW'($urandom);
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_class", 32'(out_class), 32'd1);
            check("bp_score", 32'(out_score), 32'd4);
        end
        out_ready = 1'b1;
        step();
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_count", 32'(out_count), 32'd6);
        check("bp_idle", 32'(in_ready), 32'd1);
        send(pack(2, 2, 7, 1), {2'd2, 3'd7});
        drain();

        // Abort on the second scan cycle
        do_reset();
        saw_valid = 1'b0;
        send(pack(1, 2, 3, 4), {2'd3, 3'd4});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_idle", 32'(in_ready), 32'd1);
        repeat (8) step();
        check("abort_no_valid", 32'(saw_valid), 32'd0);
        check("abort_count", 32'(out_count), 32'd0);

        // Counter wrap: 17 back-to-back results on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            send(d, ref_max(d));
        end
        drain();
        check("wrap_count", 32'(out_count), 32'd1);

        // Random vectors under random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            send(d, ref_max(d));
        end
        drain();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
